// File: rtl/demux1to4_8b_buf_pkg.sv
// demux1to4_8b_buf_pkg: shared widths and select decode for the buffered 1:4 demux
package demux1to4_8b_buf_pkg;

    localparam int DEMUX_WIDTH  = 8;
    localparam int DEMUX_NPORTS = 4;
    localparam int DEMUX_SELW   = 2;

    function automatic logic [DEMUX_NPORTS-1:0] sel_decode(input logic [DEMUX_SELW-1:0] s);
        sel_decode = '0;
        sel_decode[s] = 1'b1;
    endfunction

endpackage

// File: rtl/demux1to4_8b_buf_if.sv
// demux1to4_8b_buf_if: input valid/ready bus plus four output slot ports; in_bcast only with DEMUX_BCAST_EN
interface demux1to4_8b_buf_if
    import demux1to4_8b_buf_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH
);

    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        in_data;
    logic [DEMUX_SELW-1:0]   in_sel;
`ifdef DEMUX_BCAST_EN
    logic                    in_bcast;
`endif
    logic [DEMUX_NPORTS-1:0] out_valid;
    logic [DEMUX_NPORTS-1:0] out_ready;
    logic [WIDTH-1:0]        out_data0;
    logic [WIDTH-1:0]        out_data1;
    logic [WIDTH-1:0]        out_data2;
    logic [WIDTH-1:0]        out_data3;

`ifdef DEMUX_BCAST_EN
    modport master (
        output in_valid, in_data, in_sel, in_bcast, out_ready,
        input  in_ready, out_valid, out_data0, out_data1, out_data2, out_data3
    );
    modport slave (
        input  in_valid, in_data, in_sel, in_bcast, out_ready,
        output in_ready, out_valid, out_data0, out_data1, out_data2, out_data3
    );
`else
    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data0, out_data1, out_data2, out_data3
    );
    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data0, out_data1, out_data2, out_data3
    );
`endif

endinterface

// File: rtl/demux1to4_8b_buf_slot.sv
// demux_slot: single-entry valid/ready buffer; a fill in the same cycle as a drain keeps it full
module demux_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fill_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             ready_o
);

    logic             full_q, full_d;
    logic [WIDTH-1:0] data_q, data_d;

    // next state: fill wins over drain; a drain leaves the data register untouched
    always_comb begin
        full_d = fill_i ? 1'b1 : (full_q & ready_i) ? 1'b0 : full_q;
        data_d = fill_i ? data_i : data_q;
    end

    // slot state register, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign valid_o = full_q;
    assign data_o  = data_q;
    assign ready_o = ~full_q | ready_i;

endmodule

// File: rtl/demux1to4_8b_buf.sv
// demux1to4_8b_buf: steers each accepted word into one of four single-entry slots; DEMUX_BCAST_EN adds broadcast
module demux1to4_8b_buf
    import demux1to4_8b_buf_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH
) (
    input logic               clk,
    input logic               rst_n,
    demux1to4_8b_buf_if.slave bus
);

    logic [DEMUX_NPORTS-1:0] dest;
    logic [DEMUX_NPORTS-1:0] slot_rdy;
    logic [DEMUX_NPORTS-1:0] slot_vld;
    logic [DEMUX_NPORTS-1:0] fill;
    logic [WIDTH-1:0]        slot_data [DEMUX_NPORTS];
    logic                    in_rdy;

    // destination decode and accept decision; a broadcast needs every slot able to take the word
    always_comb begin
`ifdef DEMUX_BCAST_EN
        dest   = bus.in_bcast ? '1 : sel_decode(bus.in_sel);
        in_rdy = rst_n & (bus.in_bcast ? &slot_rdy : slot_rdy[bus.in_sel]);
`else
        dest   = sel_decode(bus.in_sel);
        in_rdy = rst_n & slot_rdy[bus.in_sel];
`endif
        fill   = dest & {DEMUX_NPORTS{bus.in_valid & in_rdy}};
    end

    for (genvar k = 0; k < DEMUX_NPORTS; k++) begin : g_slot
        demux_slot #(.WIDTH(WIDTH)) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .fill_i  (fill[k]),
            .data_i  (bus.in_data),
            .ready_i (bus.out_ready[k]),
            .valid_o (slot_vld[k]),
            .data_o  (slot_data[k]),
            .ready_o (slot_rdy[k])
        );
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = slot_vld;
    assign bus.out_data0 = slot_data[0];
    assign bus.out_data1 = slot_data[1];
    assign bus.out_data2 = slot_data[2];
    assign bus.out_data3 = slot_data[3];

endmodule

// File: tb/tb_demux1to4_8b_buf.sv
// tb_demux1to4_8b_buf: directed checks of reset, steering, backpressure, pass-through and broadcast
module tb_demux1to4_8b_buf;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_pass = 0;
    int   n_chk = 0;

    always #5 clk = ~clk;

    demux1to4_8b_buf_if bus ();

    demux1to4_8b_buf dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] sel, input logic [7:0] d);
        bus.in_valid = 1'b1;
        bus.in_sel = sel;
        bus.in_data = d;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_chk++; if (bus.out_valid !== 4'b0000) $display("FAIL rst_valid got %b want 0000", bus.out_valid); else n_pass++;
        n_chk++; if (bus.out_data0 !== 8'h00) $display("FAIL rst_d0 got %h want 00", bus.out_data0); else n_pass++;
        n_chk++; if (bus.out_data1 !== 8'h00) $display("FAIL rst_d1 got %h want 00", bus.out_data1); else n_pass++;
        n_chk++; if (bus.out_data2 !== 8'h00) $display("FAIL rst_d2 got %h want 00", bus.out_data2); else n_pass++;
        n_chk++; if (bus.out_data3 !== 8'h00) $display("FAIL rst_d3 got %h want 00", bus.out_data3); else n_pass++;
        n_chk++; if (bus.in_ready !== 1'b0) $display("FAIL rst_in_ready got %b want 0", bus.in_ready); else n_pass++;
        step();
        step();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_chk++; if (bus.in_ready !== 1'b1) $display("FAIL idle_in_ready got %b want 1", bus.in_ready); else n_pass++;
        step();
        n_chk++; if (bus.out_valid !== 4'b0000) $display("FAIL idle_valid got %b want 0000", bus.out_valid); else n_pass++;
    endtask

    task automatic test_unicast();
        bus.out_ready = 4'b0000;
        send(2'd2, 8'hA5);
        n_chk++; if (bus.out_valid !== 4'b0100) $display("FAIL uni_valid got %b want 0100", bus.out_valid); else n_pass++;
        n_chk++; if (bus.out_data2 !== 8'hA5) $display("FAIL uni_d2 got %h want a5", bus.out_data2); else n_pass++;
        n_chk++; if (bus.out_data0 !== 8'h00) $display("FAIL uni_d0 got %h want 00", bus.out_data0); else n_pass++;
        n_chk++; if (bus.out_data1 !== 8'h00) $display("FAIL uni_d1 got %h want 00", bus.out_data1); else n_pass++;
        n_chk++; if (bus.out_data3 !== 8'h00) $display("FAIL uni_d3 got %h want 00", bus.out_data3); else n_pass++;
    endtask

    task automatic test_backpressure();
        send(2'd1, 8'h77);
        bus.in_valid = 1'b1;
        bus.in_sel = 2'd1;
        bus.in_data = 8'h99;
        #1;
        n_chk++; if (bus.in_ready !== 1'b0) $display("FAIL bp_full_ready got %b want 0", bus.in_ready); else n_pass++;
        step();
        n_chk++; if (bus.out_data1 !== 8'h77) $display("FAIL bp_hold_d1 got %h want 77", bus.out_data1); else n_pass++;
        n_chk++; if (bus.out_valid !== 4'b0110) $display("FAIL bp_hold_valid got %b want 0110", bus.out_valid); else n_pass++;
        bus.in_sel = 2'd3;
        bus.in_data = 8'h3C;
        #1;
        n_chk++; if (bus.in_ready !== 1'b1) $display("FAIL bp_empty_ready got %b want 1", bus.in_ready); else n_pass++;
        step();
        bus.in_valid = 1'b0;
        n_chk++; if (bus.out_valid !== 4'b1110) $display("FAIL bp_valid got %b want 1110", bus.out_valid); else n_pass++;
        n_chk++; if (bus.out_data3 !== 8'h3C) $display("FAIL bp_d3 got %h want 3c", bus.out_data3); else n_pass++;
        n_chk++; if (bus.out_data1 !== 8'h77) $display("FAIL bp_d1 got %h want 77", bus.out_data1); else n_pass++;
    endtask

    task automatic test_pass_through();
        logic [7:0] words [3] = '{8'h01, 8'h02, 8'h03};
        bus.out_ready = 4'b0001;
        bus.in_valid = 1'b1;
        bus.in_sel = 2'd0;
        for (int i = 0; i < 3; i++) begin
            bus.in_data = words[i];
            #1;
            n_chk++; if (bus.in_ready !== 1'b1) $display("FAIL pt_ready[%0d] got %b want 1", i, bus.in_ready); else n_pass++;
            step();
            n_chk++; if (bus.out_valid[0] !== 1'b1) $display("FAIL pt_valid[%0d] got %b want 1", i, bus.out_valid[0]); else n_pass++;
            n_chk++; if (bus.out_data0 !== words[i]) $display("FAIL pt_d0[%0d] got %h want %h", i, bus.out_data0, words[i]); else n_pass++;
        end
        bus.in_valid = 1'b0;
        step();
        n_chk++; if (bus.out_valid !== 4'b1110) $display("FAIL pt_drain_valid got %b want 1110", bus.out_valid); else n_pass++;
        n_chk++; if (bus.out_data0 !== 8'h03) $display("FAIL pt_drain_d0 got %h want 03", bus.out_data0); else n_pass++;
        bus.out_ready = 4'b1111;
        step();
        bus.out_ready = 4'b0000;
        n_chk++; if (bus.out_valid !== 4'b0000) $display("FAIL pt_all_drain got %b want 0000", bus.out_valid); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 4'b0000;
        send(2'd0, 8'h11);
        send(2'd1, 8'h22);
        send(2'd2, 8'h33);
        send(2'd3, 8'h44);
        n_chk++; if (bus.out_valid !== 4'b1111) $display("FAIL mid_full got %b want 1111", bus.out_valid); else n_pass++;
        n_chk++; if (bus.out_data3 !== 8'h44) $display("FAIL mid_d3 got %h want 44", bus.out_data3); else n_pass++;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_chk++; if (bus.out_valid !== 4'b0000) $display("FAIL mid_rst_valid got %b want 0000", bus.out_valid); else n_pass++;
        n_chk++; if (bus.out_data1 !== 8'h00) $display("FAIL mid_rst_d1 got %h want 00", bus.out_data1); else n_pass++;
        #2;
        rst_n = 1'b1;
        step();
        step();
        n_chk++; if (bus.out_valid !== 4'b0000) $display("FAIL mid_post_valid got %b want 0000", bus.out_valid); else n_pass++;
        n_chk++; if (bus.out_data2 !== 8'h00) $display("FAIL mid_post_d2 got %h want 00", bus.out_data2); else n_pass++;
    endtask

`ifdef DEMUX_BCAST_EN
    task automatic test_bcast();
        bus.out_ready = 4'b0000;
        send(2'd0, 8'hEE);
        bus.in_valid = 1'b1;
        bus.in_bcast = 1'b1;
        bus.in_sel = 2'd2;
        bus.in_data = 8'h5A;
        #1;
        n_chk++; if (bus.in_ready !== 1'b0) $display("FAIL bc_stall_ready got %b want 0", bus.in_ready); else n_pass++;
        bus.out_ready = 4'b0001;
        #1;
        n_chk++; if (bus.in_ready !== 1'b1) $display("FAIL bc_ready got %b want 1", bus.in_ready); else n_pass++;
        step();
        bus.in_valid = 1'b0;
        bus.in_bcast = 1'b0;
        bus.out_ready = 4'b0000;
        n_chk++; if (bus.out_valid !== 4'b1111) $display("FAIL bc_valid got %b want 1111", bus.out_valid); else n_pass++;
        n_chk++; if ({bus.out_data0, bus.out_data1, bus.out_data2, bus.out_data3} !== 32'h5A5A5A5A)
            $display("FAIL bc_data got %h%h%h%h want 5a5a5a5a", bus.out_data0, bus.out_data1, bus.out_data2, bus.out_data3);
        else n_pass++;
    endtask
`endif

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data = 8'h00;
        bus.in_sel = 2'd0;
        bus.out_ready = 4'b0000;
`ifdef DEMUX_BCAST_EN
        bus.in_bcast = 1'b0;
`endif
        test_reset();
        test_unicast();
        test_backpressure();
        test_pass_through();
        test_reset_mid();
`ifdef DEMUX_BCAST_EN
        test_bcast();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
